// File: rtl/trap_pkg.sv
// Shared constants for the trapezoid parameter bank: breakpoint selects, defaults, FSM states.
package trap_pkg;

  localparam int unsigned TRAP_WIDTH = 8;

  localparam logic [1:0] PT_A = 2'd0;
  localparam logic [1:0] PT_B = 2'd1;
  localparam logic [1:0] PT_C = 2'd2;
  localparam logic [1:0] PT_D = 2'd3;

  localparam int unsigned TRAP_DEF_A  = 35;
  localparam int unsigned TRAP_DEF_B  = 55;
  localparam int unsigned TRAP_DEF_C  = 65;
  localparam int unsigned TRAP_DEF_D  = 84;
  localparam int unsigned TRAP_TOPO_V = 100;

  typedef enum logic [1:0] {
    StIdle,
    StCheck,
    StApply,
    StReport
  } state_e;

endpackage

// File: rtl/trap_order_check.sv
// Combinational ordering check for one trapezoid: ok when a <= b <= c <= d (ties allowed).
module trap_order_check #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  output logic             ok
);

  assign ok = (a <= b) && (b <= c) && (c <= d);

endmodule

// File: rtl/trapezio_param_bank.sv
// Programmable trapezoid breakpoint bank: shadow writes, sequential per-channel validation,
// then a single-edge copy of the whole shadow set into the active set.
module trapezio_param_bank
  import trap_pkg::*;
#(
  parameter int unsigned WIDTH  = TRAP_WIDTH,
  parameter int unsigned NUM_MF = 4,
  parameter int unsigned IDXW   = (NUM_MF > 1) ? $clog2(NUM_MF) : 1,
  parameter int unsigned DEF_A  = TRAP_DEF_A,
  parameter int unsigned DEF_B  = TRAP_DEF_B,
  parameter int unsigned DEF_C  = TRAP_DEF_C,
  parameter int unsigned DEF_D  = TRAP_DEF_D,
  parameter int unsigned TOPO_V = TRAP_TOPO_V
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [IDXW-1:0]         wr_mf,
  input  logic [1:0]              wr_pt,
  input  logic [WIDTH-1:0]        wr_data,
  input  logic                    commit_req,
  output logic                    commit_busy,
  output logic                    commit_done,
  output logic                    commit_err,
  output logic [IDXW-1:0]         err_mf,
  output logic [NUM_MF*WIDTH-1:0] a_bus,
  output logic [NUM_MF*WIDTH-1:0] b_bus,
  output logic [NUM_MF*WIDTH-1:0] c_bus,
  output logic [NUM_MF*WIDTH-1:0] d_bus,
  output logic [WIDTH-1:0]        topo,
  output logic [7:0]              cfg_gen
);

  // Bits actually needed to address a channel; IDXW may be wider.
  localparam int unsigned IW = (NUM_MF > 1) ? $clog2(NUM_MF) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_MF - 1);
  localparam logic [WIDTH-1:0] DEF_PT [4] = '{WIDTH'(DEF_A), WIDTH'(DEF_B),
                                             WIDTH'(DEF_C), WIDTH'(DEF_D)};

  logic [WIDTH-1:0] sh_q  [NUM_MF][4];
  logic [WIDTH-1:0] act_q [NUM_MF][4];

  state_e          state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            err_q, err_d;
  logic [IDXW-1:0] err_mf_q, err_mf_d;
  logic [7:0]      gen_q, gen_d;
  logic            apply;
  logic            chk_ok;
  logic            wr_fire;
  logic            wr_in_range;
  logic [IW-1:0]   cur;

  assign wr_ready    = (state_q == StIdle);
  assign wr_fire     = wr_valid && wr_ready;
  assign wr_in_range = (32'(wr_mf) < NUM_MF);
  assign cur         = idx_q[IW-1:0];

  trap_order_check #(
    .WIDTH(WIDTH)
  ) u_check (
    .a (sh_q[cur][PT_A]),
    .b (sh_q[cur][PT_B]),
    .c (sh_q[cur][PT_C]),
    .d (sh_q[cur][PT_D]),
    .ok(chk_ok)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    err_d    = err_q;
    err_mf_d = err_mf_q;
    gen_d    = gen_q;
    apply    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (commit_req) begin
          state_d = StCheck;
          idx_d   = '0;
        end
      end
      StCheck: begin
        if (!chk_ok) begin
          err_d    = 1'b1;
          err_mf_d = idx_q;
          state_d  = StReport;
        end else if (idx_q == LAST_IDX) begin
          state_d = StApply;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StApply: begin
        apply   = 1'b1;
        gen_d   = gen_q + 8'd1;
        err_d   = 1'b0;
        state_d = StReport;
      end
      StReport: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      err_q    <= 1'b0;
      err_mf_q <= '0;
      gen_q    <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      err_q    <= err_d;
      err_mf_q <= err_mf_d;
      gen_q    <= gen_d;
    end
  end

  // Shadow is frozen outside IDLE because wr_ready gates every write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int ch = 0; ch < NUM_MF; ch++) begin
        for (int p = 0; p < 4; p++) begin
          sh_q[ch][p] <= DEF_PT[p];
        end
      end
    end else if (wr_fire && wr_in_range) begin
      sh_q[wr_mf[IW-1:0]][wr_pt] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int ch = 0; ch < NUM_MF; ch++) begin
        for (int p = 0; p < 4; p++) begin
          act_q[ch][p] <= DEF_PT[p];
        end
      end
    end else if (apply) begin
      act_q <= sh_q;
    end
  end

  always_comb begin
    a_bus = '0;
    b_bus = '0;
    c_bus = '0;
    d_bus = '0;
    for (int ch = 0; ch < NUM_MF; ch++) begin
      a_bus[ch*WIDTH +: WIDTH] = act_q[ch][PT_A];
      b_bus[ch*WIDTH +: WIDTH] = act_q[ch][PT_B];
      c_bus[ch*WIDTH +: WIDTH] = act_q[ch][PT_C];
      d_bus[ch*WIDTH +: WIDTH] = act_q[ch][PT_D];
    end
  end

  assign commit_busy = (state_q != StIdle);
  assign commit_done = (state_q == StReport);
  assign commit_err  = err_q;
  assign err_mf      = err_mf_q;
  assign topo        = WIDTH'(TOPO_V);
  assign cfg_gen     = gen_q;

endmodule

// File: tb/tb_trapezio_param_bank.sv
// Randomized self-checking bench for trapezio_param_bank against an array-based model.
module tb_trapezio_param_bank;

  localparam int NMF = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [2:0]  wr_mf = '0;
  logic [1:0]  wr_pt = '0;
  logic [7:0]  wr_data = '0;
  logic        commit_req = 1'b0;
  logic        commit_busy, commit_done, commit_err;
  logic [2:0]  err_mf;
  logic [31:0] a_bus, b_bus, c_bus, d_bus;
  logic [7:0]  topo, cfg_gen;

  int n_cmp = 0;
  int n_bad = 0;

  int sh_m  [NMF][4];
  int act_m [NMF][4];
  int gen_m;

  always #5 clk = ~clk;

  trapezio_param_bank #(
    .NUM_MF(4),
    .IDXW  (3)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_mf      (wr_mf),
    .wr_pt      (wr_pt),
    .wr_data    (wr_data),
    .commit_req (commit_req),
    .commit_busy(commit_busy),
    .commit_done(commit_done),
    .commit_err (commit_err),
    .err_mf     (err_mf),
    .a_bus      (a_bus),
    .b_bus      (b_bus),
    .c_bus      (c_bus),
    .d_bus      (d_bus),
    .topo       (topo),
    .cfg_gen    (cfg_gen)
  );

  task automatic model_reset();
    int defs [4];
    defs = '{35, 55, 65, 84};
    for (int ch = 0; ch < NMF; ch++)
      for (int p = 0; p < 4; p++) begin
        sh_m[ch][p]  = defs[p];
        act_m[ch][p] = defs[p];
      end
    gen_m = 0;
  endtask

  function automatic logic [31:0] exp_bus(int p);
    logic [31:0] r;
    for (int ch = 0; ch < NMF; ch++) r[ch*8 +: 8] = 8'(act_m[ch][p]);
    return r;
  endfunction

  // Index of the first channel violating a<=b<=c<=d, or -1 if every channel is ordered.
  function automatic int first_fail();
    for (int ch = 0; ch < NMF; ch++)
      if (!(sh_m[ch][0] <= sh_m[ch][1] && sh_m[ch][1] <= sh_m[ch][2] &&
            sh_m[ch][2] <= sh_m[ch][3])) return ch;
    return -1;
  endfunction

  task automatic do_write(input int mf, input int pt, input int data);
    @(negedge clk);
    wr_valid = 1'b1;
    wr_mf    = 3'(mf);
    wr_pt    = 2'(pt);
    wr_data  = 8'(data);
    @(negedge clk);
    wr_valid = 1'b0;
    if (mf < NMF) sh_m[mf][pt] = data;
  endtask

  // Drives one commit; lat is cycles from the sampling edge to commit_done (-1 on timeout).
  task automatic do_commit(output int lat, output logic err, output logic [2:0] emf,
                           output logic [31:0] pre_a, output logic busy);
    @(negedge clk);
    commit_req = 1'b1;
    @(negedge clk);
    commit_req = 1'b0;
    busy  = commit_busy;
    lat   = 0;
    pre_a = a_bus;
    while (commit_done !== 1'b1 && lat < 40) begin
      if (lat == NMF) pre_a = a_bus;
      @(negedge clk);
      lat++;
    end
    if (lat >= 40) lat = -1;
    err = commit_err;
    emf = err_mf;
  endtask

  task automatic apply_model();
    for (int ch = 0; ch < NMF; ch++)
      for (int p = 0; p < 4; p++) act_m[ch][p] = sh_m[ch][p];
    gen_m = (gen_m + 1) % 256;
  endtask

  task automatic check_active(input string tag);
    for (int p = 0; p < 4; p++) begin
      logic [31:0] got;
      logic [31:0] want;
      want = exp_bus(p);
      got  = (p == 0) ? a_bus : (p == 1) ? b_bus : (p == 2) ? c_bus : d_bus;
      n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL %s bus%0d got=%h want=%h", tag, p, got, want);
      end
    end
    n_cmp++;
    if (cfg_gen !== 8'(gen_m)) begin
      n_bad++;
      $display("FAIL %s cfg_gen got=%0d want=%0d", tag, cfg_gen, gen_m);
    end
  endtask

  // Commit and compare latency, result and active set against the model.
  task automatic commit_and_check(input string tag);
    int          lat, ff, want_lat;
    logic        err, busy;
    logic [2:0]  emf;
    logic [31:0] pre_a, old_a;
    ff       = first_fail();
    want_lat = (ff < 0) ? NMF + 1 : ff + 1;
    old_a    = exp_bus(0);
    do_commit(lat, err, emf, pre_a, busy);
    n_cmp++;
    if (lat != want_lat) begin
      n_bad++;
      $display("FAIL %s latency got=%0d want=%0d", tag, lat, want_lat);
    end
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL %s busy got=%b want=1", tag, busy);
    end
    n_cmp++;
    if (err !== (ff >= 0)) begin
      n_bad++;
      $display("FAIL %s commit_err got=%b want=%b", tag, err, ff >= 0);
    end
    if (ff >= 0) begin
      n_cmp++;
      if (emf !== 3'(ff)) begin
        n_bad++;
        $display("FAIL %s err_mf got=%0d want=%0d", tag, emf, ff);
      end
    end else begin
      n_cmp++;
      if (pre_a !== old_a) begin
        n_bad++;
        $display("FAIL %s a_bus_before_apply got=%h want=%h", tag, pre_a, old_a);
      end
      apply_model();
    end
    check_active(tag);
  endtask

  task automatic test_reset();
    check_active("reset");
    n_cmp++;
    if (topo !== 8'd100) begin
      n_bad++;
      $display("FAIL reset topo got=%0d want=100", topo);
    end
    n_cmp++;
    if ({wr_ready, commit_busy, commit_done, commit_err, err_mf} !== 7'b1000_000) begin
      n_bad++;
      $display("FAIL reset ctrl got=%b want=1000000",
               {wr_ready, commit_busy, commit_done, commit_err, err_mf});
    end
  endtask

  task automatic test_pass();
    do_write(2, 0, 5);
    do_write(2, 1, 77);
    do_write(2, 2, 153);
    do_write(2, 3, 222);
    commit_and_check("pass_ch2");
  endtask

  task automatic test_reject();
    do_write(1, 1, 60);
    do_write(1, 2, 40);
    commit_and_check("reject_ch1");
  endtask

  task automatic test_edges();
    do_write(1, 2, 70);
    for (int p = 0; p < 4; p++) do_write(0, p, 0);
    for (int p = 0; p < 4; p++) do_write(3, p, 255);
    do_write(7, 0, 200);
    commit_and_check("edges");
  endtask

  task automatic test_same_edge();
    int lat;
    do_write(0, 3, 84);
    do_write(0, 2, 65);
    do_write(0, 1, 55);
    @(negedge clk);
    wr_valid = 1'b1; wr_mf = 3'd0; wr_pt = 2'd0; wr_data = 8'd10;
    commit_req = 1'b1;
    @(negedge clk);
    sh_m[0][0] = 10;
    commit_req = 1'b0;
    wr_data = 8'd50;
    n_cmp++;
    if (wr_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL same_edge wr_ready_in_check got=%b want=0", wr_ready);
    end
    @(negedge clk);
    wr_valid = 1'b0;
    lat = 1;
    while (commit_done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    n_cmp++;
    if (lat != NMF + 1 || commit_err !== 1'b0) begin
      n_bad++;
      $display("FAIL same_edge result got lat=%0d err=%b want lat=%0d err=0",
               lat, commit_err, NMF + 1);
    end
    apply_model();
    check_active("same_edge");
  endtask

  task automatic test_random();
    for (int it = 0; it < 24; it++) begin
      int nw;
      if ($urandom_range(1, 0) == 1) begin
        int v [4];
        int mf, t;
        mf = $urandom_range(NMF - 1, 0);
        for (int p = 0; p < 4; p++) v[p] = $urandom_range(255, 0);
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3 - i; j++)
            if (v[j] > v[j+1]) begin t = v[j]; v[j] = v[j+1]; v[j+1] = t; end
        for (int p = 0; p < 4; p++) do_write(mf, p, v[p]);
      end
      nw = $urandom_range(3, 0);
      for (int k = 0; k < nw; k++)
        do_write($urandom_range(7, 0), $urandom_range(3, 0), $urandom_range(255, 0));
      commit_and_check($sformatf("rand%0d", it));
    end
  endtask

  task automatic test_wrap();
    // Restore a fully ordered shadow so every commit passes.
    for (int ch = 0; ch < NMF; ch++) begin
      do_write(ch, 0, 35); do_write(ch, 1, 55); do_write(ch, 2, 65); do_write(ch, 3, 84);
    end
    for (int i = 0; i < 256; i++) begin
      int          lat;
      logic        err, busy;
      logic [2:0]  emf;
      logic [31:0] pre_a;
      do_commit(lat, err, emf, pre_a, busy);
      apply_model();
      n_cmp++;
      if (cfg_gen !== 8'(gen_m) || err !== 1'b0) begin
        n_bad++;
        $display("FAIL wrap%0d gen/err got=%0d/%b want=%0d/0", i, cfg_gen, err, gen_m);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_write(1, 0, 12);
    @(negedge clk);
    commit_req = 1'b1;
    @(negedge clk);
    commit_req = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_active("reset_mid");
    n_cmp++;
    if (commit_busy !== 1'b0 || wr_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_mid ctrl got busy=%b ready=%b want busy=0 ready=1",
               commit_busy, wr_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    commit_and_check("after_reset");
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_pass();
    test_reject();
    test_edges();
    test_same_edge();
    test_random();
    test_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
